// File: rtl/parking_pkg.sv
// Shared types and helpers for the four-spot parking controller.
//   NUM_SPOTS   : number of parking spots (fixed at 4)
//   spot_idx_t  : index of one spot
//   spot_map_t  : one bit per spot (occupancy or free map)
//   lowest_free : lowest-numbered spot whose occupancy bit is 0
//   popcount4   : number of set bits in a spot map (0-4)
package parking_pkg;

  localparam int NUM_SPOTS = 4;

  typedef logic [1:0] spot_idx_t;
  typedef logic [3:0] spot_map_t;

  // Result is only meaningful when at least one bit of occ is 0.
  function automatic spot_idx_t lowest_free(input spot_map_t occ);
    spot_idx_t idx;
    idx = '0;
    // Scan downward so the lowest free index is the one that sticks.
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occ[i]) idx = spot_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] popcount4(input spot_map_t m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/spot_timer.sv
// Occupancy-duration counter for a single parking spot.
// Counts clock cycles while the spot is occupied, saturating at all-ones,
// holds the last value while the spot is free, and restarts from 0 when a
// new car is admitted into the spot.
//   CLK      : system clock
//   RST      : asynchronous active-high reset
//   clear    : a car is admitted into this spot at this edge
//   occupied : registered occupancy bit of this spot
//   count    : current duration in cycles
module spot_timer #(
  parameter int TIME_W = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              occupied,
  output logic [TIME_W-1:0] count
);

  logic [TIME_W-1:0] count_q;
  logic [TIME_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    // Admission wins over counting: the new stay starts from zero.
    if (clear) begin
      count_d = '0;
    end else if (occupied && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/parking_circuit.sv
// Four-spot parking-lot controller.
// Admits a car into the lowest-numbered free spot on each rising edge of
// `enter`, releases spot `switch` on each rising edge of `exit`, holds the
// door open for DOOR_CYCLES cycles after every accepted entry, and reports
// occupancy, free count and full status.
// Optional feature: define SPOT_TIMER_EN to build the per-spot occupancy
// timers; without it spot0_time..spot3_time are constant 0.
//   CLK, RST             : clock, asynchronous active-high reset
//   enter, exit          : arrival / departure requests (edge-detected)
//   switch               : spot released by an exit event
//   full, full_light     : all spots occupied
//   door_open, open_light: door open after an accepted entry
//   capacity             : number of free spots
//   L                    : spot given to the most recently admitted car
//   F, E                 : occupied / free bitmaps
//   spot0_time..3_time   : occupancy duration of each spot, in cycles
module parking_circuit
  import parking_pkg::*;
#(
  parameter int DOOR_CYCLES = 4,
  parameter int TIME_W      = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enter,
  input  logic              exit,
  input  logic [1:0]        switch,
  output logic              full,
  output logic              door_open,
  output logic [2:0]        capacity,
  output logic [1:0]        L,
  output logic [3:0]        F,
  output logic [3:0]        E,
  output logic [TIME_W-1:0] spot0_time,
  output logic [TIME_W-1:0] spot1_time,
  output logic [TIME_W-1:0] spot2_time,
  output logic [TIME_W-1:0] spot3_time,
  output logic              open_light,
  output logic              full_light
);

  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_CYCLES);

  logic      enter_q, enter_d;
  logic      exit_q,  exit_d;
  spot_map_t f_q,     f_d;
  spot_idx_t l_q,     l_d;
  logic [DW-1:0] door_q, door_d;

  logic      enter_ev;
  logic      exit_ev;
  logic      accept;
  spot_idx_t slot;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    enter_d  = enter;
    exit_d   = exit;
    f_d      = f_q;
    l_d      = l_q;
    door_d   = door_q;

    enter_ev = enter & ~enter_q;
    exit_ev  = exit & ~exit_q;
    accept   = enter_ev && (f_q != 4'hF);
    // Chosen from the pre-exit map, so a simultaneous entry never takes the
    // spot that is being freed in the same cycle.
    slot     = lowest_free(f_q);

    if (door_q != '0) door_d = door_q - 1'b1;

    if (exit_ev && f_q[switch]) f_d[switch] = 1'b0;

    if (accept) begin
      f_d[slot] = 1'b1;
      l_d       = slot;
      door_d    = DOOR_LOAD;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      f_q     <= '0;
      l_q     <= '0;
      door_q  <= '0;
    end else begin
      enter_q <= enter_d;
      exit_q  <= exit_d;
      f_q     <= f_d;
      l_q     <= l_d;
      door_q  <= door_d;
    end
  end

  assign F          = f_q;
  assign E          = ~f_q;
  assign L          = l_q;
  assign capacity   = popcount4(~f_q);
  assign full       = (f_q == 4'hF);
  assign full_light = full;
  assign door_open  = (door_q != '0);
  assign open_light = door_open;

`ifdef SPOT_TIMER_EN
  logic [TIME_W-1:0] spot_time [NUM_SPOTS];

  for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_timer
    spot_timer #(.TIME_W(TIME_W)) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .clear    (accept && (slot == spot_idx_t'(i))),
      .occupied (f_q[i]),
      .count    (spot_time[i])
    );
  end

  assign spot0_time = spot_time[0];
  assign spot1_time = spot_time[1];
  assign spot2_time = spot_time[2];
  assign spot3_time = spot_time[3];
`else
  assign spot0_time = '0;
  assign spot1_time = '0;
  assign spot2_time = '0;
  assign spot3_time = '0;
`endif

endmodule

// File: tb/tb_parking_circuit.sv
// Directed self-checking bench for parking_circuit (DOOR_CYCLES=4, TIME_W=64).
// Timer expectations follow SPOT_TIMER_EN: measured from the entry edge when
// defined, constant 0 otherwise. Entry gaps are scaled down to keep runs short.
module tb_parking_circuit;

  localparam int DOOR  = 4;
  localparam int TW    = 64;
  localparam int GAP   = 200;
  localparam int HOLD  = 150;

  logic          CLK = 1'b0;
  logic          RST;
  logic          enter;
  logic          exit;
  logic [1:0]    switch;
  logic          full;
  logic          door_open;
  logic [2:0]    capacity;
  logic [1:0]    L;
  logic [3:0]    F;
  logic [3:0]    E;
  logic [TW-1:0] spot0_time, spot1_time, spot2_time, spot3_time;
  logic          open_light;
  logic          full_light;

  int     n_total = 0;
  int     n_pass  = 0;
  longint cyc     = 0;
  longint ent [4];
  longint frozen2;
  int     door_cnt;

  parking_circuit #(.DOOR_CYCLES(DOOR), .TIME_W(TW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enter      (enter),
    .exit       (exit),
    .switch     (switch),
    .full       (full),
    .door_open  (door_open),
    .capacity   (capacity),
    .L          (L),
    .F          (F),
    .E          (E),
    .spot0_time (spot0_time),
    .spot1_time (spot1_time),
    .spot2_time (spot2_time),
    .spot3_time (spot3_time),
    .open_light (open_light),
    .full_light (full_light)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Expected timer value: elapsed cycles when timers exist, else 0.
  function automatic logic [63:0] t_exp(input longint v);
`ifdef SPOT_TIMER_EN
    return 64'(v);
`else
    return 64'(v - v);
`endif
  endfunction

  // Counts cycles the door stays open, bounded; ends with the door closed.
  task automatic wait_door(output int n);
    n = 0;
    while (door_open && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic enter_pulse();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic exit_pulse(input logic [1:0] s);
    switch = s;
    exit   = 1'b1;
    tick();
    exit   = 1'b0;
    tick();
  endtask

  initial begin
    RST = 1'b1; enter = 1'b0; exit = 1'b0; switch = 2'd0;
    repeat (3) tick();
    RST = 1'b0;
    repeat (2) tick();

    // Reset / idle state
    check("rst_F", F, 4'b0000);
    check("rst_E", E, 4'b1111);
    check("rst_cap", capacity, 3'd4);
    check("rst_full", full, 1'b0);
    check("rst_door", door_open, 1'b0);
    check("rst_L", L, 2'd0);

    // Four spaced entries fill spots 0..3
    for (int i = 0; i < 4; i++) begin
      enter_pulse();
      ent[i] = cyc;
      check($sformatf("ent%0d_L", i), L, 64'(i));
      check($sformatf("ent%0d_cap", i), capacity, 64'(3 - i));
      check($sformatf("ent%0d_light", i), open_light, 1'b1);
      wait_door(door_cnt);
      check($sformatf("ent%0d_door_cycles", i), door_cnt, DOOR);
      repeat (i < 3 ? GAP : HOLD) tick();
    end
    check("full", full, 1'b1);
    check("full_light", full_light, 1'b1);
    check("full_F", F, 4'b1111);
    check("t0", spot0_time, t_exp(cyc - ent[0]));
    check("t1", spot1_time, t_exp(cyc - ent[1]));
    check("t2", spot2_time, t_exp(cyc - ent[2]));
    check("t3", spot3_time, t_exp(cyc - ent[3]));

    // Release spot 2: its timer counts through the exit edge, then freezes
    switch = 2'd2;
    exit   = 1'b1;
    tick();
    exit   = 1'b0;
    frozen2 = cyc - ent[2];
    check("x2_F", F, 4'b1011);
    check("x2_E", E, 4'b0100);
    check("x2_cap", capacity, 3'd1);
    check("x2_full", full, 1'b0);
    repeat (10) tick();
    check("x2_frozen", spot2_time, t_exp(frozen2));

    // Re-entry lands in spot 2 and restarts its timer
    enter_pulse();
    ent[2] = cyc;
    check("re_L", L, 2'd2);
    check("re_full", full, 1'b1);
    check("re_t2_zero", spot2_time, 64'd0);
    wait_door(door_cnt);
    check("re_t2_run", spot2_time, t_exp(cyc - ent[2]));

    // Entry into a full lot is ignored
    enter_pulse();
    check("fullent_F", F, 4'b1111);
    check("fullent_L", L, 2'd2);
    check("fullent_cap", capacity, 3'd0);
    check("fullent_door", door_open, 1'b0);
    tick();

    // Free spot 0, then exit on the already-free spot 0 does nothing
    exit_pulse(2'd0);
    check("x0_F", F, 4'b1110);
    exit_pulse(2'd0);
    check("x0again_F", F, 4'b1110);
    check("x0again_cap", capacity, 3'd1);

    // Enter held for 20 cycles admits exactly one car
    enter    = 1'b1;
    door_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (door_open) door_cnt++;
    end
    enter = 1'b0;
    tick();
    check("hold_cap", capacity, 3'd0);
    check("hold_L", L, 2'd0);
    check("hold_door_cycles", door_cnt, DOOR);

    // Reach F=0011, then simultaneous entry and exit of spot 0
    exit_pulse(2'd3);
    exit_pulse(2'd2);
    check("pre_F", F, 4'b0011);
    switch = 2'd0;
    enter  = 1'b1;
    exit   = 1'b1;
    tick();
    enter  = 1'b0;
    exit   = 1'b0;
    check("both_F", F, 4'b0110);
    check("both_L", L, 2'd2);
    check("both_cap", capacity, 3'd2);

    // Asynchronous reset while the door counter is running
    tick();
    RST = 1'b1;
    #1;
    check("arst_F", F, 4'b0000);
    check("arst_E", E, 4'b1111);
    check("arst_cap", capacity, 3'd4);
    check("arst_full", full, 1'b0);
    check("arst_L", L, 2'd0);
    check("arst_door", door_open, 1'b0);
    check("arst_open_light", open_light, 1'b0);
    check("arst_t1", spot1_time, 64'd0);
    check("arst_t2", spot2_time, 64'd0);
    tick();
    RST = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/parking_circuit.md
Name: parking_circuit

Overview:
- Four-spot parking-lot controller.
- Tracks which spots are occupied and admits cars on `enter` pulses into the lowest-numbered free spot. Releases the spot selected by `switch` on `exit` pulses.
- Drives door and full indicators and keeps a per-spot occupancy-duration counter.
- Top-level leaf block between board I/O (buttons, switches, LEDs) and any display logic.

Parameters:
- DOOR_CYCLES, 4: number of clock cycles `door_open` stays high after an accepted entry (must be ≥1).
- TIME_W, 64: width of each spot timer.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- enter  in  1  car-arrival request; acted on at its rising edge.
- exit  in  1  car-departure request; acted on at its rising edge.
- switch  in  2  index (0-3) of the spot being vacated on `exit`.
- full  out  1  high when all 4 spots are occupied.
- door_open  out  1  high for DOOR_CYCLES cycles after an accepted entry.
- capacity  out  3  number of free spots, 0-4.
- L  out  2  spot index assigned to the most recently admitted car.
- F  out  4  occupancy bitmap; bit i=1 means spot i is occupied.
- E  out  4  free bitmap, always equal to ~F.
- spot0_time .. spot3_time  out  TIME_W each  occupancy duration of spot i, in clock cycles.
- open_light  out  1  LED copy of `door_open`.
- full_light  out  1  LED copy of `full`.

Behaviour:
- Reset (asynchronous, RST=1) values:
  - F=0000, E=1111, capacity=4, full=0, L=00, door_open=0.
  - All spot timers 0; internal edge-detect registers 0.
- Edge detection:
  - enter_q and exit_q register the previous cycle's inputs.
  - An entry event is enter & ~enter_q; an exit event is exit & ~exit_q.
  - Holding a request high produces exactly one event.
- Entry event with F≠1111:
  - Choose k = lowest index with F[k]=0, using F before this cycle's update.
  - At the same edge: set F[k], load L=k, load the door counter with DOOR_CYCLES, clear spot k's timer.
- Entry event with F=1111: ignored. F, L and the door are unchanged.
- Exit event with F[switch]=1: clear F[switch] at the same edge; spot `switch`'s timer freezes.
- Exit event with F[switch]=0: ignored.
- Entry and exit events in the same cycle:
  - Both are applied.
  - The entry chooses from the pre-exit F, so it never takes the spot freed in that cycle.
  - Net capacity is unchanged.
- Combinational outputs, all reflecting the registered F:
  - E=~F; capacity=popcount(E); full=(F==1111); full_light=full; open_light=door_open.
  - All update one cycle after the triggering edge is registered, i.e. visible after the clock edge that sampled the event.
- Door counter:
  - door_open = (counter≠0); the counter decrements each cycle while nonzero.
  - A new accepted entry while the door is open reloads DOOR_CYCLES.
- Spot timers:
  - While F[i]=1, the timer increments by 1 every cycle, saturating at all-ones.
  - While F[i]=0 it holds its last value (readable duration of the last stay) until cleared by the next entry into spot i.
- Reset mid-operation: immediate return to the reset values. Events pending on that cycle are lost.

Optional Feature:
- Macro SPOT_TIMER_EN.
- Defined: spot timers are implemented as described above.
- Undefined: no timer registers exist, and spot0_time..spot3_time are tied to 0. All other behaviour is identical.

Decomposition:
- Package parking_pkg:
  - NUM_SPOTS=4.
  - typedef spot_idx_t (2-bit).
  - typedef spot_map_t (4-bit).
  - Function lowest_free(spot_map_t) returning spot_idx_t.
  - Function popcount4.
- One natural sub-module, spot_timer:
  - Ports: CLK, RST, clear, occupied, count[TIME_W].
  - Instantiated 4×, only under SPOT_TIMER_EN.

Test Plan:
- Reset then idle → F=0000, E=1111, capacity=4, full=0, door_open=0, L=00.
- Four one-cycle `enter` pulses, each 2,000,000 cycles apart:
  - L=0,1,2,3 in turn; capacity goes 3,2,1,0; full=full_light=1 after the 4th.
  - door_open=open_light high exactly DOOR_CYCLES cycles after each pulse.
  - Cars enter at cycles T, T+2,000,000, T+4,000,000, T+6,000,000. Checked 1,500,000 cycles after the 4th entry (cycle T+7,500,000), the timers are: spot0_time ≈ 7,500,000, spot1_time ≈ 5,500,000, spot2_time ≈ 3,500,000, spot3_time ≈ 1,500,000.
- Full lot, then switch=10 with an exit pulse:
  - F=1011, E=0100, capacity=1, full=0.
  - spot2_time freezes at its value. A 5th enter pulse → L=2, spot2_time restarts from 0, full=1.
- `enter` held high 20 cycles → exactly one admission: capacity drops by 1, door_open high DOOR_CYCLES cycles.
- Full lot plus an enter pulse → F, L, capacity unchanged, door_open stays 0. An exit pulse on a free spot → no change.
- F=0011 with simultaneous enter and exit pulses, switch=00 → F=0110, L=2, capacity stays 2. Asserting RST mid-count returns every output to its reset value immediately.
